// File: rtl/program_counter.sv
// program_counter: 32-bit instruction fetch address register.
// Counts up by PC_STEP every cycle after a synchronous active-high reset
// to RESET_VECTOR. Wraps silently modulo 2^32.
// Optional feature macro: PC_CTRL_EN adds stall/load control and a
// registered misaligned-target flag. Per-edge priority is
// rst > load > stall > increment.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PC_CTRL_EN
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_addr,
  output logic        misaligned,
`endif
  output logic [31:0] pc_out
);

  // Low two bits are forced to zero so pc_out stays word aligned even if a
  // parameter override is careless.
  localparam logic [31:0] RESET_ALIGNED = {RESET_VECTOR[31:2], 2'b00};
  localparam logic [31:0] STEP_ALIGNED  = {PC_STEP[31:2], 2'b00};

  logic [31:0] pc_next;

  // Next-address selection (reset handled in the register).
  always_comb begin
    pc_next = pc_out + STEP_ALIGNED;
`ifdef PC_CTRL_EN
    if (load) begin
      pc_next = {load_addr[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc_out;
    end
`endif
  end

  // Program counter register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= RESET_ALIGNED;
    end else begin
      pc_out <= pc_next;
    end
  end

`ifdef PC_CTRL_EN
  // Misaligned flag tracks the low bits of the most recently accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (load) begin
      misaligned <= |load_addr[1:0];
    end
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
// Works in both builds; the PC_CTRL_EN section runs only when the macro is
// defined. Extra instances cover the wrap-around and a non-default step.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] pc_wrap;
  logic [31:0] pc_step8;
`ifdef PC_CTRL_EN
  logic        stall;
  logic        load;
  logic [31:0] load_addr;
  logic        misaligned;
  logic        stall_w;
  logic        load_w;
  logic        mis_w;
  logic        stall_s;
  logic        load_s;
  logic        mis_s;
`endif

  int unsigned num_checks;
  int unsigned num_errors;

  program_counter u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PC_CTRL_EN
    .stall     (stall),
    .load      (load),
    .load_addr (load_addr),
    .misaligned(misaligned),
`endif
    .pc_out    (pc_out)
  );

  program_counter #(
    .RESET_VECTOR(32'hFFFF_FFF8),
    .PC_STEP     (32'd4)
  ) u_wrap (
    .clk       (clk),
    .rst       (rst),
`ifdef PC_CTRL_EN
    .stall     (stall_w),
    .load      (load_w),
    .load_addr (32'h0),
    .misaligned(mis_w),
`endif
    .pc_out    (pc_wrap)
  );

  program_counter #(
    .RESET_VECTOR(32'h0000_0100),
    .PC_STEP     (32'd8)
  ) u_step8 (
    .clk       (clk),
    .rst       (rst),
`ifdef PC_CTRL_EN
    .stall     (stall_s),
    .load      (load_s),
    .load_addr (32'h0),
    .misaligned(mis_s),
`endif
    .pc_out    (pc_step8)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at the falling edge, so one rising edge happens
  // before the next falling edge where outputs are checked.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    rst = 1'b1;
`ifdef PC_CTRL_EN
    stall = 1'b0; load = 1'b0; load_addr = 32'h0;
    stall_w = 1'b0; load_w = 1'b0;
    stall_s = 1'b0; load_s = 1'b0;
`endif

    // Reset and hold while rst stays high.
    step();
    check("reset_pc", pc_out, 32'h0);
    check("reset_wrap", pc_wrap, 32'hFFFF_FFF8);
    check("reset_step8", pc_step8, 32'h0000_0100);
`ifdef PC_CTRL_EN
    check("reset_mis", {31'b0, misaligned}, 32'h0);
`endif
    step();
    check("reset_hold", pc_out, 32'h0);

    // Basic count to 0x28 over ten edges; wrap and step-8 instances alongside.
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("count", pc_out, 32'(4 * i));
      check("step8", pc_step8, 32'(32'h100 + 8 * i));
      if (i <= 3) check("wrap", pc_wrap, 32'(32'hFFFF_FFF8 + 4 * i));
    end
    check("count_end", pc_out, 32'h28);

    // Mid-run reset, count up to 0x1C, reset again, then release.
    rst = 1'b1;
    step();
    check("midrst_a", pc_out, 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("at_1c", pc_out, 32'h1C);
    rst = 1'b1;
    step();
    check("midrst_b", pc_out, 32'h0);
    rst = 1'b0;
    step();
    check("after_rst", pc_out, 32'h4);

`ifdef PC_CTRL_EN
    // Wrap-around through a load.
    load = 1'b1; load_addr = 32'hFFFF_FFF8;
    step();
    check("ld_wrap0", pc_out, 32'hFFFF_FFF8);
    check("ld_wrap_mis", {31'b0, misaligned}, 32'h0);
    load = 1'b0;
    step();
    check("ld_wrap1", pc_out, 32'hFFFF_FFFC);
    step();
    check("ld_wrap2", pc_out, 32'h0);
    step();
    check("ld_wrap3", pc_out, 32'h4);

    // Load beats stall; misaligned target is truncated and flagged.
    stall = 1'b1; load = 1'b1; load_addr = 32'h0000_1003;
    step();
    check("ld_prio_pc", pc_out, 32'h0000_1000);
    check("ld_prio_mis", {31'b0, misaligned}, 32'h1);
    load = 1'b0;
    step();
    check("stall_pc", pc_out, 32'h0000_1000);
    check("stall_mis", {31'b0, misaligned}, 32'h1);
    stall = 1'b0;
    step();
    check("unstall_pc", pc_out, 32'h0000_1004);
    check("unstall_mis", {31'b0, misaligned}, 32'h1);

    // Aligned load clears the flag.
    load = 1'b1; load_addr = 32'h0000_2000;
    step();
    check("ld_al_pc", pc_out, 32'h0000_2000);
    check("ld_al_mis", {31'b0, misaligned}, 32'h0);

    // Set the flag again, then reset must win over a simultaneous load.
    load_addr = 32'h0000_3002;
    step();
    check("ld_mis2", {31'b0, misaligned}, 32'h1);
    rst = 1'b1; load_addr = 32'h40;
    step();
    check("rst_dom_pc", pc_out, 32'h0);
    check("rst_dom_mis", {31'b0, misaligned}, 32'h0);
    rst = 1'b0; load = 1'b0;
    step();
    check("rst_dom_next", pc_out, 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000: value loaded into pc_out on reset; bits [1:0] SHALL be zero.
REQ-002 SHALL provide parameter PC_STEP, default 32'd4: increment per enabled cycle; SHALL be a nonzero multiple of 4.
REQ-003 SHALL provide port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port pc_out, output, 32 bits: current program counter, driven directly from a register.
REQ-006 SHALL provide port stall, input, 1 bit, only when PC_CTRL_EN is defined: hold pc_out.
REQ-007 SHALL provide port load, input, 1 bit, only when PC_CTRL_EN is defined: load a new target.
REQ-008 SHALL provide port load_addr, input, 32 bits, only when PC_CTRL_EN is defined: branch or jump target.
REQ-009 SHALL provide port misaligned, output, 1 bit, only when PC_CTRL_EN is defined: registered flag, set when the last accepted load_addr had bits [1:0] != 0.

Function
REQ-010 SHALL update pc_out only on the rising edge of clk; no combinational path from any input to pc_out.
REQ-011 SHALL, on each rising edge with no higher-priority condition, set pc_out <= pc_out + PC_STEP, modulo 2^32.
REQ-012 SHALL wrap around silently: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag or stall.
REQ-013 SHALL apply this priority per edge: rst > load > stall > increment.
REQ-014 SHALL, on load, set pc_out <= {load_addr[31:2], 2'b00}; stall SHALL be ignored in that cycle.
REQ-015 SHALL, on stall without load, keep pc_out unchanged.
REQ-016 SHALL set misaligned <= |load_addr[1:0] on each accepted load, and SHALL leave it unchanged otherwise.
REQ-017 SHALL have a latency of one cycle: a value applied at edge N is visible on pc_out after edge N.
REQ-018 SHALL keep pc_out 4-byte aligned at all times, i.e. pc_out[1:0] == 2'b00.

Reset
REQ-019 SHALL, on a rising edge with rst=1, set pc_out <= RESET_VECTOR and misaligned <= 0, regardless of all other inputs.
REQ-020 SHALL let rst asserted mid-count take effect at the next edge and hold RESET_VECTOR while rst stays high.
REQ-021 SHALL increment on the first edge after rst deasserts, producing RESET_VECTOR + PC_STEP.
REQ-022 SHALL leave pc_out unspecified before the first reset edge; a bench SHALL NOT check it.

Configuration
REQ-023 SHALL use macro PC_CTRL_EN: when defined, the stall, load, load_addr and misaligned ports and logic exist.
REQ-024 SHALL, without PC_CTRL_EN, have exactly the ports clk, rst and pc_out, and increment unconditionally after reset.

Verification
REQ-025 SHALL cover basic count: 100 MHz clk, rst=1 for one edge then 0 -> pc_out = 0x0, 0x4, 0x8, ... reaching 0x28 on the 10th edge after release.
REQ-026 SHALL cover mid-run reset: pc_out=0x1C, assert rst for one edge -> 0x0, then 0x4 on the next edge.
REQ-027 SHALL cover wrap-around: load 0xFFFF_FFF8 -> 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-028 SHALL cover load priority (PC_CTRL_EN): stall=1 and load=1 with load_addr=0x0000_1003 -> pc_out=0x0000_1000 and misaligned=1; next edge with stall=1 and load=0 -> holds 0x0000_1000.
REQ-029 SHALL cover reset dominance (PC_CTRL_EN): rst=1, load=1, load_addr=0x40 -> pc_out=0x0 and misaligned=0.
REQ-030 SHALL cover the build without PC_CTRL_EN: compiles with only clk, rst and pc_out connected, and REQ-025 passes.
